pipeline_merge_rr: RTL and testbench
====================================

PIPELINE_MERGE_RR -- requirements
Module: pipeline_merge_rr

Interface
REQ-001 Parameter Name, default "", debug label; no effect on function.
REQ-002 Parameter Width, default 8, data bits per input channel and per output.
REQ-003 Parameter NumInputs, default 2, number of input channels; legal range 2..16.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port d  input  NumInputs*Width  input payloads; channel i occupies bits [i*Width +: Width].
REQ-007 Port d_valid  input  NumInputs  per-channel token present.
REQ-008 Port d_bp  output  NumInputs  per-channel backpressure; a token on channel i is consumed iff d_valid[i] && ~d_bp[i].
REQ-009 Port q  output  Width  merged payload, driven from output slot 1.
REQ-010 Port q_valid  output  1  output token present.
REQ-011 Port q_bp  input  1  downstream backpressure; token leaves iff q_valid && ~q_bp.
REQ-012 Port q_src  output  clog2(NumInputs)  index of the channel that supplied q.

Function
REQ-013 Two-slot output buffer (slot1 = output, slot2 = overflow): full = both slots valid; the block accepts at most one input token per cycle, and only when ~full.
REQ-014 Grant: exactly one channel is granted per cycle when ~full and any d_valid is set; d_bp[i] = ~grant[i], combinational from d_valid, full and the priority pointer.
REQ-015 Round-robin: search starts at channel ptr, wraps NumInputs-1 -> 0; after a grant to channel k, ptr <= (k+1) mod NumInputs; ptr is unchanged when there is no grant.
REQ-016 Latency: a token accepted in cycle N appears on q/q_valid in cycle N+1 if slot1 was empty or was emptied in cycle N; otherwise it waits in slot2.
REQ-017 Outgoing without incoming: slot1 <= slot2 (data, src, valid); slot2 invalid.
REQ-018 Incoming without outgoing: fill slot1 if empty, else fill slot2.
REQ-019 Incoming and outgoing together: slot2 shifts to slot1 and the new token goes to slot2 if slot2 was valid; otherwise the new token goes to slot1.
REQ-020 Token order on q equals grant order; no token is duplicated or dropped.
REQ-021 q and q_src are don't-care while q_valid = 0 but hold stable while q_valid && q_bp.

Reset
REQ-022 While reset is high: q_valid = 0, both slots invalid, ptr = 0, q = 0, q_src = 0, all d_bp = 1.
REQ-023 Reset asserted mid-transfer discards buffered tokens; the first grant after release follows the ptr = 0 order.

Configuration
REQ-024 Macro PIPELINE_MERGE_LOCK_EN, when defined, adds port d_last (input, NumInputs bits); a grant to channel k then locks the arbiter to k until a token with d_last[k] = 1 is accepted from k.
REQ-025 Locked state: grant only to k, other channels held under d_bp; ptr advances to k+1 only on acceptance of the last token; the lock is cleared by reset.
REQ-026 Macro undefined: no d_last port; arbitration is per token as in REQ-014/REQ-015.

Structure
REQ-027 Package pipeline_pkg holds the clog2-based index-width function and the lock-state enum (ARB_IDLE, ARB_LOCKED).
REQ-028 Sub-module merge_rr_arbiter holds the grant logic, ptr and lock FSM; the top level holds the two-slot buffer.

Verification
REQ-029 NumInputs=2, d_valid=2'b11 held, q_bp=0, d0=0xA*, d1=0xB* -> q alternates A0,B0,A1,B1; one token per cycle after the first-cycle latency.
REQ-030 Only channel 1 valid, 4 tokens, q_bp=0 -> 4 consecutive q beats, q_src=1, d_bp[0]=1 throughout.
REQ-031 q_bp=1 held with both channels valid -> exactly 2 tokens absorbed, then d_bp=2'b11; release q_bp -> order preserved, nothing lost.
REQ-032 NumInputs=3, only channels 0 and 2 valid -> grants go 0,2,0,2 (ptr skips idle channel 1, wrap from 2 to 0).
REQ-033 Reset pulse asserted with 2 tokens buffered -> q_valid=0 and all d_bp=1 immediately (asynchronous), ptr=0 after release.
REQ-034 PIPELINE_MERGE_LOCK_EN defined: channel 0 sends a 3-token packet (d_last on the 3rd) while channel 1 is valid -> q shows 0,0,0 then channel 1.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and helpers for the round-robin pipeline merge.
// The optional PIPELINE_MERGE_LOCK_EN build uses the lock-state enum defined here.
package pipeline_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : int'($clog2(n));
  endfunction

endpackage

// File: rtl/merge_rr_arbiter.sv
// Round-robin grant logic with rotating priority pointer.
// PIPELINE_MERGE_LOCK_EN adds d_last and holds the grant on one channel until a packet ends.
module merge_rr_arbiter
  import pipeline_pkg::*;
#(
  parameter int unsigned NumInputs = 2,
  parameter int unsigned IdxW      = idx_width(NumInputs)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NumInputs-1:0] d_valid,
`ifdef PIPELINE_MERGE_LOCK_EN
  input  logic [NumInputs-1:0] d_last,
`endif
  output logic [NumInputs-1:0] grant,
  output logic [IdxW-1:0]      grant_idx
);

  logic [IdxW-1:0] ptr;
  logic [IdxW-1:0] ptr_next;
  logic [IdxW-1:0] search_idx;
  logic            search_hit;
  logic            sel_hit;
  logic            ptr_adv;
  logic            accept;

  // First valid channel at or after ptr, wrapping past the top index.
  always_comb begin
    int unsigned c;
    c          = 0;
    search_idx = '0;
    search_hit = 1'b0;
    for (int unsigned j = 0; j < NumInputs; j++) begin
      c = (32'(ptr) + j) % NumInputs;
      if (!search_hit && d_valid[IdxW'(c)]) begin
        search_hit = 1'b1;
        search_idx = IdxW'(c);
      end
    end
  end

`ifdef PIPELINE_MERGE_LOCK_EN
  arb_state_t      state;
  logic [IdxW-1:0] lock_ch;

  always_comb begin
    grant_idx = search_idx;
    sel_hit   = search_hit;
    if (state == ARB_LOCKED) begin
      grant_idx = lock_ch;
      sel_hit   = d_valid[lock_ch];
    end
  end

  assign ptr_adv = d_last[grant_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ARB_IDLE;
      lock_ch <= '0;
    end else if (accept) begin
      if (d_last[grant_idx]) begin
        state <= ARB_IDLE;
      end else begin
        state   <= ARB_LOCKED;
        lock_ch <= grant_idx;
      end
    end
  end
`else
  assign grant_idx = search_idx;
  assign sel_hit   = search_hit;
  assign ptr_adv   = 1'b1;
`endif

  assign accept   = enable & sel_hit;
  assign ptr_next = (grant_idx == IdxW'(NumInputs - 1)) ? '0 : grant_idx + IdxW'(1);

  always_comb begin
    grant = '0;
    if (accept) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (accept && ptr_adv) begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/pipeline_merge_rr.sv
// N-to-1 round-robin merge into a two-slot output buffer (slot1 drives q, slot2 absorbs overflow).
// Define PIPELINE_MERGE_LOCK_EN to add d_last and packet-locked arbitration.
module pipeline_merge_rr
  import pipeline_pkg::*;
#(
  parameter string       Name      = "",
  parameter int unsigned Width     = 8,
  parameter int unsigned NumInputs = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NumInputs*Width-1:0]     d,
  input  logic [NumInputs-1:0]           d_valid,
`ifdef PIPELINE_MERGE_LOCK_EN
  input  logic [NumInputs-1:0]           d_last,
`endif
  output logic [NumInputs-1:0]           d_bp,
  output logic [Width-1:0]               q,
  output logic                           q_valid,
  input  logic                           q_bp,
  output logic [idx_width(NumInputs)-1:0] q_src
);

  localparam int unsigned IdxW = idx_width(NumInputs);

  logic                 s1_v, s2_v;
  logic [Width-1:0]     s1_d, s2_d;
  logic [IdxW-1:0]      s1_src, s2_src;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic [NumInputs-1:0] grant;
  logic [IdxW-1:0]      grant_idx;
  logic [Width-1:0]     in_d;

  assign full = s1_v & s2_v;

  merge_rr_arbiter #(
    .NumInputs(NumInputs),
    .IdxW     (IdxW)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .enable   (~full & ~reset),
    .d_valid  (d_valid),
`ifdef PIPELINE_MERGE_LOCK_EN
    .d_last   (d_last),
`endif
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  assign d_bp    = ~grant;
  assign push    = |grant;
  assign pop     = s1_v & ~q_bp;
  assign in_d    = d[32'(grant_idx)*Width +: Width];
  assign q       = s1_d;
  assign q_valid = s1_v;
  assign q_src   = s1_src;

  // slot2 is only ever occupied behind slot1, so a push never meets a full pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v   <= 1'b0;
      s1_d   <= '0;
      s1_src <= '0;
      s2_v   <= 1'b0;
      s2_d   <= '0;
      s2_src <= '0;
    end else begin
      if (pop && !push) begin
        s1_v   <= s2_v;
        s1_d   <= s2_d;
        s1_src <= s2_src;
        s2_v   <= 1'b0;
      end else if (push && !pop) begin
        if (!s1_v) begin
          s1_v   <= 1'b1;
          s1_d   <= in_d;
          s1_src <= grant_idx;
        end else begin
          s2_v   <= 1'b1;
          s2_d   <= in_d;
          s2_src <= grant_idx;
        end
      end else if (push && pop) begin
        if (s2_v) begin
          s1_d   <= s2_d;
          s1_src <= s2_src;
          s2_d   <= in_d;
          s2_src <= grant_idx;
        end else begin
          s1_d   <= in_d;
          s1_src <= grant_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipeline_merge_rr.sv
// Directed table-driven bench for pipeline_merge_rr (2- and 3-input instances).
module tb_pipeline_merge_rr;

  logic        clk = 1'b0;
  logic        reset;

  logic [15:0] d2;
  logic [1:0]  dv2;
  logic [1:0]  bp2;
  logic [7:0]  q2;
  logic        qv2;
  logic        qbp2;
  logic [0:0]  qsrc2;

  logic [23:0] d3;
  logic [2:0]  dv3;
  logic [2:0]  bp3;
  logic [7:0]  q3;
  logic        qv3;
  logic        qbp3;
  logic [1:0]  qsrc3;

`ifdef PIPELINE_MERGE_LOCK_EN
  logic [1:0]  dl2;
  logic [2:0]  dl3;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_merge_rr #(.Name("m2"), .Width(8), .NumInputs(2)) u2 (
    .clk(clk), .reset(reset), .d(d2), .d_valid(dv2),
`ifdef PIPELINE_MERGE_LOCK_EN
    .d_last(dl2),
`endif
    .d_bp(bp2), .q(q2), .q_valid(qv2), .q_bp(qbp2), .q_src(qsrc2)
  );

  pipeline_merge_rr #(.Name("m3"), .Width(8), .NumInputs(3)) u3 (
    .clk(clk), .reset(reset), .d(d3), .d_valid(dv3),
`ifdef PIPELINE_MERGE_LOCK_EN
    .d_last(dl3),
`endif
    .d_bp(bp3), .q(q3), .q_valid(qv3), .q_bp(qbp3), .q_src(qsrc3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0] dv;
    logic       qbp;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       eqv;
    logic [7:0] eq;
    logic       esrc;
    logic [1:0] ebp;
  } vec_t;

  vec_t vecs [21];

  initial begin
    // alternation, single-channel stream, backpressure fill/drain
    vecs[0]  = '{2'b11, 1'b0, 8'hA0, 8'hB0, 1'b0, 8'h00, 1'b0, 2'b10};
    vecs[1]  = '{2'b11, 1'b0, 8'hA1, 8'hB0, 1'b1, 8'hA0, 1'b0, 2'b01};
    vecs[2]  = '{2'b11, 1'b0, 8'hA1, 8'hB1, 1'b1, 8'hB0, 1'b1, 2'b10};
    vecs[3]  = '{2'b11, 1'b0, 8'hA2, 8'hB1, 1'b1, 8'hA1, 1'b0, 2'b01};
    vecs[4]  = '{2'b00, 1'b0, 8'hA2, 8'hB2, 1'b1, 8'hB1, 1'b1, 2'b11};
    vecs[5]  = '{2'b00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 2'b11};
    vecs[6]  = '{2'b10, 1'b0, 8'h00, 8'hC0, 1'b0, 8'h00, 1'b0, 2'b01};
    vecs[7]  = '{2'b10, 1'b0, 8'h00, 8'hC1, 1'b1, 8'hC0, 1'b1, 2'b01};
    vecs[8]  = '{2'b10, 1'b0, 8'h00, 8'hC2, 1'b1, 8'hC1, 1'b1, 2'b01};
    vecs[9]  = '{2'b10, 1'b0, 8'h00, 8'hC3, 1'b1, 8'hC2, 1'b1, 2'b01};
    vecs[10] = '{2'b00, 1'b0, 8'h00, 8'h00, 1'b1, 8'hC3, 1'b1, 2'b11};
    vecs[11] = '{2'b00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 2'b11};
    vecs[12] = '{2'b11, 1'b1, 8'hD0, 8'hE0, 1'b0, 8'h00, 1'b0, 2'b10};
    vecs[13] = '{2'b11, 1'b1, 8'hD1, 8'hE0, 1'b1, 8'hD0, 1'b0, 2'b01};
    vecs[14] = '{2'b11, 1'b1, 8'hD1, 8'hE1, 1'b1, 8'hD0, 1'b0, 2'b11};
    vecs[15] = '{2'b11, 1'b1, 8'hD1, 8'hE1, 1'b1, 8'hD0, 1'b0, 2'b11};
    vecs[16] = '{2'b11, 1'b0, 8'hD1, 8'hE1, 1'b1, 8'hD0, 1'b0, 2'b11};
    vecs[17] = '{2'b00, 1'b0, 8'h00, 8'h00, 1'b1, 8'hE0, 1'b1, 2'b11};
    vecs[18] = '{2'b11, 1'b0, 8'hD1, 8'hE1, 1'b0, 8'h00, 1'b0, 2'b10};
    vecs[19] = '{2'b00, 1'b0, 8'h00, 8'h00, 1'b1, 8'hD1, 1'b0, 2'b11};
    vecs[20] = '{2'b00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 2'b11};

    reset = 1'b1;
    d2 = '0; dv2 = 2'b11; qbp2 = 1'b0;
    d3 = '0; dv3 = 3'b111; qbp3 = 1'b0;
`ifdef PIPELINE_MERGE_LOCK_EN
    dl2 = 2'b11;
    dl3 = 3'b111;
`endif

    // reset state, with every channel requesting
    @(negedge clk);
    check("rst_qv2", qv2, 1'b0);
    check("rst_bp2", bp2, 2'b11);
    check("rst_q2", q2, 8'h00);
    check("rst_src2", qsrc2, 1'b0);
    check("rst_qv3", qv3, 1'b0);
    check("rst_bp3", bp3, 3'b111);
    dv2 = '0; dv3 = '0;
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      dv2  = vecs[i].dv;
      qbp2 = vecs[i].qbp;
      d2   = {vecs[i].d1, vecs[i].d0};
      @(negedge clk);
      check($sformatf("v%0d_qv", i), qv2, vecs[i].eqv);
      check($sformatf("v%0d_bp", i), bp2, vecs[i].ebp);
      if (vecs[i].eqv) begin
        check($sformatf("v%0d_q", i), q2, vecs[i].eq);
        check($sformatf("v%0d_src", i), qsrc2, vecs[i].esrc);
      end
      @(posedge clk); #1;
    end

    // ptr is now 1: fill both slots under backpressure, then reset asynchronously
    dv2 = 2'b11; qbp2 = 1'b1; d2 = {8'h61, 8'h51};
    @(negedge clk);
    check("pre_rst_bp_a", bp2, 2'b01);
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_q", q2, 8'h61);
    check("pre_rst_bp_b", bp2, 2'b10);
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_full", bp2, 2'b11);
    #2 reset = 1'b1;
    #1;
    check("async_rst_qv", qv2, 1'b0);
    check("async_rst_bp", bp2, 2'b11);
    check("async_rst_q", q2, 8'h00);
    check("async_rst_src", qsrc2, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0; qbp2 = 1'b0;
    @(negedge clk);
    check("post_rst_bp", bp2, 2'b10);
    @(posedge clk); #1;
    dv2 = 2'b00;
    @(negedge clk);
    check("post_rst_qv", qv2, 1'b1);
    check("post_rst_q", q2, 8'h51);
    check("post_rst_src", qsrc2, 1'b0);
    @(posedge clk); #1;

    // three inputs, channel 1 idle: grants alternate 0,2 with wrap
    dv3 = 3'b101; d3 = {8'h20, 8'h00, 8'h10}; qbp3 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      int unsigned g;
      int unsigned gp;
      g  = (k % 2 == 0) ? 0 : 2;
      gp = (k % 2 == 0) ? 2 : 0;
      @(negedge clk);
      check($sformatf("n3_bp%0d", k), bp3, (g == 0) ? 3'b110 : 3'b011);
      check($sformatf("n3_qv%0d", k), qv3, (k > 0) ? 1'b1 : 1'b0);
      if (k > 0) begin
        check($sformatf("n3_src%0d", k), qsrc3, gp[1:0]);
        check($sformatf("n3_q%0d", k), q3, (gp == 0) ? 8'h10 : 8'h20);
      end
      @(posedge clk); #1;
    end
    dv3 = '0;

`ifdef PIPELINE_MERGE_LOCK_EN
    // three-token packet on channel 0 holds off channel 1
    reset = 1'b1;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    dv2 = 2'b11; dl2 = 2'b10; d2 = {8'h80, 8'h70};
    @(negedge clk);
    check("lk_bp0", bp2, 2'b10);
    @(posedge clk); #1;
    d2 = {8'h80, 8'h71};
    @(negedge clk);
    check("lk_bp1", bp2, 2'b10);
    check("lk_q1", q2, 8'h70);
    @(posedge clk); #1;
    d2 = {8'h80, 8'h72}; dl2 = 2'b11;
    @(negedge clk);
    check("lk_bp2", bp2, 2'b10);
    check("lk_q2", q2, 8'h71);
    @(posedge clk); #1;
    dl2 = 2'b10;
    @(negedge clk);
    check("lk_bp3", bp2, 2'b01);
    check("lk_q3", q2, 8'h72);
    check("lk_src3", qsrc2, 1'b0);
    @(posedge clk); #1;
    dv2 = 2'b00;
    @(negedge clk);
    check("lk_q4", q2, 8'h80);
    check("lk_src4", qsrc2, 1'b1);
    @(posedge clk); #1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
